// File: rtl/sea_round_ctrl.sv
// rtl/sea_round_ctrl.sv - SEA block-cipher round sequencer driving an external single-round datapath
//
// Purpose:
//   Sequences NR rounds of the SEA cipher over an external combinational round
//   datapath. A block is captured on start and then iterated one round per clock
//   through rnd_l/rnd_r/rnd_k -> rnd_lo/rnd_ro/rnd_ko. The final round's output is
//   latched into lo/ro and announced with a one-cycle done pulse. This block does
//   no arithmetic on the data words; it only steers and registers them.
//
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   start, mode         - block request (taken only while ready) and enc/dec select
//   li, ri, ki          - input halves and key, captured with start
//   ready, busy         - IDLE indicator / RUN-or-DONE indicator
//   rnd_l, rnd_r, rnd_k - current state/key registers to the round datapath
//   rnd_lo, rnd_ro,
//   rnd_ko              - next state/key from the round datapath
//   rnd_en, rnd_dec     - round-apply strobe and latched direction
//   rnd_idx, key_swap   - current round index, key-schedule half-swap round flag
//   lo, ro, done        - result of the last completed block and its valid pulse

module sea_round_ctrl #(
  parameter int NR = 104
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mode,
  input  logic [47:0] li,
  input  logic [47:0] ri,
  input  logic [47:0] ki,
  output logic        ready,
  output logic        busy,
  output logic [47:0] rnd_l,
  output logic [47:0] rnd_r,
  output logic [47:0] rnd_k,
  input  logic [47:0] rnd_lo,
  input  logic [47:0] rnd_ro,
  input  logic [47:0] rnd_ko,
  output logic        rnd_en,
  output logic        rnd_dec,
  output logic [6:0]  rnd_idx,
  output logic        key_swap,
  output logic [47:0] lo,
  output logic [47:0] ro,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Round index is only ever compared at 7 bits.
  localparam logic [6:0] LAST_IDX = 7'(NR - 1);
  localparam logic [6:0] SWAP_IDX = 7'(NR / 2);

  state_t      state_q, state_d;
  logic [47:0] l_q, l_d;
  logic [47:0] r_q, r_d;
  logic [47:0] k_q, k_d;
  logic [47:0] lo_q, lo_d;
  logic [47:0] ro_q, ro_d;
  logic [6:0]  idx_q, idx_d;
  logic        dec_q, dec_d;
  logic        en_q, en_d;
  logic        swap_q, swap_d;
  logic        done_q, done_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    k_d     = k_q;
    lo_d    = lo_q;
    ro_d    = ro_q;
    idx_d   = idx_q;
    dec_d   = dec_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          l_d     = li;
          r_d     = ri;
          k_d     = ki;
          dec_d   = mode;
          idx_d   = 7'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Every RUN edge applies one round, including the last one.
        l_d = rnd_lo;
        r_d = rnd_ro;
        k_d = rnd_ko;
        if (idx_q == LAST_IDX) begin
          // Index parks at NR-1; it is only cleared on the way out of DONE.
          lo_d    = rnd_lo;
          ro_d    = rnd_ro;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 7'd1;
        end
      end
      S_DONE: begin
        idx_d   = 7'd0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered, so they are derived from the next state.
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    en_d    = (state_d == S_RUN);
    swap_d  = (state_d == S_RUN) && (idx_d == SWAP_IDX);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      l_q     <= 48'd0;
      r_q     <= 48'd0;
      k_q     <= 48'd0;
      lo_q    <= 48'd0;
      ro_q    <= 48'd0;
      idx_q   <= 7'd0;
      dec_q   <= 1'b0;
      en_q    <= 1'b0;
      swap_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      k_q     <= k_d;
      lo_q    <= lo_d;
      ro_q    <= ro_d;
      idx_q   <= idx_d;
      dec_q   <= dec_d;
      en_q    <= en_d;
      swap_q  <= swap_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign rnd_l    = l_q;
  assign rnd_r    = r_q;
  assign rnd_k    = k_q;
  assign rnd_en   = en_q;
  assign rnd_dec  = dec_q;
  assign rnd_idx  = idx_q;
  assign key_swap = swap_q;
  assign lo       = lo_q;
  assign ro       = ro_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sea_round_ctrl.sv
// tb/tb_sea_round_ctrl.sv - scoreboard bench for sea_round_ctrl (NR=104 and NR=2 instances)

module tb_sea_round_ctrl;

  localparam int NR0 = 104;
  localparam int NR1 = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [47:0] li = 48'd0;
  logic [47:0] ri = 48'd0;
  logic [47:0] ki = 48'd0;

  logic        ready [2];
  logic        busy [2];
  logic        rnd_en [2];
  logic        rnd_dec [2];
  logic        key_swap [2];
  logic        done [2];
  logic [6:0]  rnd_idx [2];
  logic [47:0] rnd_l [2];
  logic [47:0] rnd_r [2];
  logic [47:0] rnd_k [2];
  logic [47:0] rnd_lo [2];
  logic [47:0] rnd_ro [2];
  logic [47:0] rnd_ko [2];
  logic [47:0] lo [2];
  logic [47:0] ro [2];

  always #5 clk = ~clk;

  // Stub round datapath: increment left half, pass right half and key.
  for (genvar g = 0; g < 2; g++) begin : g_stub
    assign rnd_lo[g] = rnd_l[g] + 48'd1;
    assign rnd_ro[g] = rnd_r[g];
    assign rnd_ko[g] = rnd_k[g];
  end

  sea_round_ctrl #(.NR(NR0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .li(li), .ri(ri), .ki(ki),
    .ready(ready[0]), .busy(busy[0]),
    .rnd_l(rnd_l[0]), .rnd_r(rnd_r[0]), .rnd_k(rnd_k[0]),
    .rnd_lo(rnd_lo[0]), .rnd_ro(rnd_ro[0]), .rnd_ko(rnd_ko[0]),
    .rnd_en(rnd_en[0]), .rnd_dec(rnd_dec[0]), .rnd_idx(rnd_idx[0]),
    .key_swap(key_swap[0]), .lo(lo[0]), .ro(ro[0]), .done(done[0])
  );

  sea_round_ctrl #(.NR(NR1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .li(li), .ri(ri), .ki(ki),
    .ready(ready[1]), .busy(busy[1]),
    .rnd_l(rnd_l[1]), .rnd_r(rnd_r[1]), .rnd_k(rnd_k[1]),
    .rnd_lo(rnd_lo[1]), .rnd_ro(rnd_ro[1]), .rnd_ko(rnd_ko[1]),
    .rnd_en(rnd_en[1]), .rnd_dec(rnd_dec[1]), .rnd_idx(rnd_idx[1]),
    .key_swap(key_swap[1]), .lo(lo[1]), .ro(ro[1]), .done(done[1])
  );

  typedef struct packed {
    logic [47:0] lo;
    logic [47:0] ro;
    int          edge_n;
  } exp_t;

  exp_t        sbq [2][$];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  // Reference model: per-instance block phase counted in clock edges since acceptance.
  bit          m_act [2];
  int          m_ph [2];
  bit          m_dec [2];
  logic [47:0] m_li [2];
  logic [47:0] m_ri [2];
  logic [47:0] m_ki [2];
  logic [47:0] m_lo [2];
  logic [47:0] m_ro [2];

  function automatic int nr_of(input int d);
    return (d == 0) ? NR0 : NR1;
  endfunction

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, d, cyc, act, exp);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 1'b0; m_ph[d] = 0; m_dec[d] = 1'b0;
      m_li[d] = 48'd0; m_ri[d] = 48'd0; m_ki[d] = 48'd0;
      m_lo[d] = 48'd0; m_ro[d] = 48'd0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        int n;
        n = nr_of(d);
        if (!rst_n) begin
          m_act[d] = 1'b0; m_ph[d] = 0; m_dec[d] = 1'b0;
          m_lo[d] = 48'd0; m_ro[d] = 48'd0;
          sbq[d].delete();
        end else if (m_act[d]) begin
          m_ph[d]++;
          if (m_ph[d] == n) begin
            m_lo[d] = m_li[d] + 48'(n);
            m_ro[d] = m_ri[d];
          end else if (m_ph[d] == n + 1) begin
            m_act[d] = 1'b0;
          end
        end else if (start) begin
          m_act[d] = 1'b1; m_ph[d] = 0; m_dec[d] = mode;
          m_li[d] = li; m_ri[d] = ri; m_ki[d] = ki;
          sbq[d].push_back('{lo: li + 48'(n), ro: ri, edge_n: cyc + n});
        end
      end
    end
  end

  // Monitor: per-cycle status against the model, and scoreboard pop on done.
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      int n;
      logic [12:0] st_a, st_e;
      exp_t e;
      n = nr_of(d);
      st_a = {ready[d], busy[d], rnd_en[d], key_swap[d], done[d], rnd_dec[d], rnd_idx[d]};
      if (!m_act[d])
        st_e = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, m_dec[d], 7'd0};
      else if (m_ph[d] < n)
        st_e = {1'b0, 1'b1, 1'b1, m_ph[d] == n / 2, 1'b0, m_dec[d], 7'(m_ph[d])};
      else
        st_e = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, m_dec[d], 7'(n - 1)};
      chk("status", d, 64'(st_a), 64'(st_e));
      chk("lo_hold", d, 64'(lo[d]), 64'(m_lo[d]));
      chk("ro_hold", d, 64'(ro[d]), 64'(m_ro[d]));
      if (m_act[d] && m_ph[d] < n) begin
        chk("rnd_l", d, 64'(rnd_l[d]), 64'(m_li[d] + 48'(m_ph[d])));
        chk("rnd_r", d, 64'(rnd_r[d]), 64'(m_ri[d]));
        chk("rnd_k", d, 64'(rnd_k[d]), 64'(m_ki[d]));
      end
      if (sbq[d].size() > 0 && sbq[d][0].edge_n < cyc) begin
        tests++;
        fails++;
        $display("FAIL done_missing dut%0d cycle %0d: got no done expected done at %0d", d, cyc, sbq[d][0].edge_n);
        void'(sbq[d].pop_front());
      end
      if (done[d] === 1'b1) begin
        if (sbq[d].size() == 0) begin
          tests++;
          fails++;
          $display("FAIL done_unexpected dut%0d cycle %0d: got done expected none", d, cyc);
        end else begin
          e = sbq[d].pop_front();
          chk("sb_lo", d, 64'(lo[d]), 64'(e.lo));
          chk("sb_ro", d, 64'(ro[d]), 64'(e.ro));
          chk("sb_time", d, 64'(cyc), 64'(e.edge_n));
        end
      end
    end
  end

  task automatic rand_data();
    li   = {16'($urandom()), $urandom()};
    ri   = {16'($urandom()), $urandom()};
    ki   = {16'($urandom()), $urandom()};
    mode = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int en_cnt;
    int ks_hits;
    bit ks_ok;
    int guard;

    // Reset with start held high: start must be ignored.
    rst_n = 1'b0;
    start = 1'b1;
    rand_data();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);

    // Directed block: li=0, ri=0xABCDEF012345.
    li = 48'd0; ri = 48'hABCDEF012345; ki = 48'h0000_1234_5678; mode = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    en_cnt = 0; ks_hits = 0; ks_ok = 1'b1;
    for (int i = 0; i <= NR0; i++) begin
      if (i > 0) @(negedge clk);
      if (rnd_en[0]) en_cnt++;
      if (key_swap[0]) begin
        ks_hits++;
        if (rnd_idx[0] != 7'd52) ks_ok = 1'b0;
      end
      if (i == NR1) begin
        chk("nr2_done", 1, 64'(done[1]), 64'd1);
        chk("nr2_lo", 1, 64'(lo[1]), 64'd2);
      end
    end
    chk("dir_done", 0, 64'(done[0]), 64'd1);
    chk("dir_lo", 0, 64'(lo[0]), 64'h000000000068);
    chk("dir_ro", 0, 64'(ro[0]), 64'hABCDEF012345);
    chk("dir_en_cnt", 0, 64'(en_cnt), 64'd104);
    chk("dir_ks_hits", 0, 64'(ks_hits), 64'd1);
    chk("dir_ks_idx", 0, 64'(ks_ok), 64'd1);
    @(negedge clk);

    // start held high: back-to-back blocks, data/mode changing every cycle.
    start = 1'b1;
    for (int i = 0; i < 3 * (NR0 + 2) + 10; i++) begin
      rand_data();
      @(negedge clk);
    end
    start = 1'b0;
    repeat (NR0 + 4) @(negedge clk);

    // Reset in the middle of a block at round index 50.
    rand_data();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(m_act[0] && m_ph[0] == 50) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_idx50", 0, 64'(guard < 200), 64'd1);
    chk("idx50", 0, 64'(rnd_idx[0]), 64'd50);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", 0, 64'(ready[0]), 64'd1);
    chk("rst_lo", 0, 64'(lo[0]), 64'd0);
    chk("rst_done", 0, 64'(done[0]), 64'd0);
    rand_data();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (NR0 + 4) @(negedge clk);

    // Decrypt block with mode toggling and li changing during RUN.
    rand_data();
    mode = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < NR0 + 3; i++) begin
      mode = ~mode;
      li = {16'($urandom()), $urandom()};
      @(negedge clk);
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rand_data();
      start = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 399) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (NR0 + 4) @(negedge clk);

    chk("sb_empty0", 0, 64'(sbq[0].size()), 64'd0);
    chk("sb_empty1", 1, 64'(sbq[1].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
